// File: rtl/wb_select_pipe_if.sv
// Bus bundle for wb_select_pipe: execute-side request, load return, writeback and bypass query.
// The execute/memory stage drives through master; the select pipe sits on slave.
interface wb_select_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        md;
  logic [ADDR_W-1:0] rd;
  logic              rw;
  logic [DATA_W-1:0] func_out;
  logic              nxorv;
  logic [DATA_W-1:0] pc_link;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;
  logic [ADDR_W-1:0] fwd_qaddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, md, rd, rw, func_out, nxorv, pc_link, ld_size, ld_signed,
           mem_valid, mem_rdata, fwd_qaddr,
    input  in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_err, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, md, rd, rw, func_out, nxorv, pc_link, ld_size, ld_signed,
           mem_valid, mem_rdata, fwd_qaddr,
    output in_ready, wb_valid, wb_we, wb_addr, wb_data, wb_err, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_select_pipe.sv
// Registered writeback select: picks FUNC/DATA/FLAG/LINK, waits for load data with timeout,
// extends sub-word loads. Optional macro WB_FWD_EN enables the writeback bypass outputs.
module wb_select_pipe #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  wb_select_pipe_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_WRITE} state_e;

  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic              ld_rw_q, ld_rw_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_signed_q, ld_signed_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_err_q, wb_err_d;
  logic              accept;
  logic [DATA_W-1:0] ext_data;

  assign bus.in_ready = ~reset & (state_q != S_WAIT_MEM);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    ext_data = bus.mem_rdata;
    if (!ld_size_q[1]) begin
      if (ld_size_q[0])
        ext_data = {{(DATA_W-16){ld_signed_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      else
        ext_data = {{(DATA_W-8){ld_signed_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    ld_rd_d     = ld_rd_q;
    ld_rw_d     = ld_rw_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_err_d    = wb_err_q;
    case (state_q)
      S_IDLE, S_WRITE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (bus.md == 2'd1) begin
            // Load: hold destination aside so wb_* keep their last value while waiting.
            state_d     = S_WAIT_MEM;
            tmo_cnt_d   = 8'd0;
            ld_rd_d     = bus.rd;
            ld_rw_d     = bus.rw;
            ld_size_d   = bus.ld_size;
            ld_signed_d = bus.ld_signed;
          end else begin
            state_d   = S_WRITE;
            wb_addr_d = bus.rd;
            wb_we_d   = bus.rw & (bus.rd != '0);
            wb_err_d  = 1'b0;
            case (bus.md)
              2'd0:    wb_data_d = bus.func_out;
              2'd2:    wb_data_d = {{(DATA_W-1){1'b0}}, bus.nxorv};
              default: wb_data_d = bus.pc_link;
            endcase
          end
        end
      end
      S_WAIT_MEM: begin
        if (bus.mem_valid) begin
          state_d   = S_WRITE;
          wb_addr_d = ld_rd_q;
          wb_we_d   = ld_rw_q & (ld_rd_q != '0);
          wb_data_d = ext_data;
          wb_err_d  = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_WRITE;
          wb_addr_d = ld_rd_q;
          wb_we_d   = ld_rw_q & (ld_rd_q != '0);
          wb_data_d = '0;
          wb_err_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmo_cnt_q   <= 8'd0;
      ld_rd_q     <= '0;
      ld_rw_q     <= 1'b0;
      ld_size_q   <= 2'd0;
      ld_signed_q <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ld_rd_q     <= ld_rd_d;
      ld_rw_q     <= ld_rw_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign bus.wb_valid = (state_q == S_WRITE);
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_err   = wb_err_q;

`ifdef WB_FWD_EN
  assign bus.fwd_hit  = (state_q == S_WRITE) & wb_we_q & (bus.fwd_qaddr == wb_addr_q);
  assign bus.fwd_data = bus.fwd_hit ? wb_data_q : '0;
`else
  logic unused_fwd_qaddr;
  assign unused_fwd_qaddr = ^bus.fwd_qaddr;
  assign bus.fwd_hit      = 1'b0;
  assign bus.fwd_data     = '0;
`endif
endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: table of single-cycle selects plus hand sequences
// for loads, extension, timeout and reset during a pending load.
module tb_wb_select_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  wb_select_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  wb_select_pipe #(.DATA_W(DW), .ADDR_W(AW), .LOAD_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  md;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] func_out;
    logic        nxorv;
    logic [31:0] pc_link;
    logic [4:0]  qaddr;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_fwd(input string name, input logic exp_hit, input logic [31:0] exp_data);
`ifdef WB_FWD_EN
    chk({name, "_hit"}, bus.fwd_hit, exp_hit);
    chk({name, "_data"}, bus.fwd_data, exp_hit ? exp_data : 32'h0);
`else
    chk({name, "_hit"}, bus.fwd_hit, 1'b0);
    chk({name, "_data"}, bus.fwd_data, 32'h0);
`endif
  endtask

  // Accept a load, deliver data in WAIT_MEM cycle `delay` (0 = never), check the pulse.
  task automatic do_load(input string name, input logic [1:0] size, input logic sgn,
                         input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic exp_err);
    int wait_cycles;
    bus.in_valid  = 1'b1;
    bus.md        = 2'd1;
    bus.rd        = rd;
    bus.rw        = 1'b1;
    bus.ld_size   = size;
    bus.ld_signed = sgn;
    bus.mem_valid = 1'b1;          // must be ignored in the acceptance cycle
    bus.mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.mem_valid = 1'b0;
    wait_cycles = (delay == 0) ? 15 : delay;
    for (int c = 1; c <= wait_cycles; c++) begin
      chk({name, "_busy_ready"}, bus.in_ready, 1'b0);
      chk({name, "_busy_valid"}, bus.wb_valid, 1'b0);
      if (c == delay) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(negedge clk);
      bus.mem_valid = 1'b0;
    end
    chk({name, "_valid"}, bus.wb_valid, 1'b1);
    chk({name, "_data"}, bus.wb_data, exp_data);
    chk({name, "_err"}, bus.wb_err, exp_err);
    chk({name, "_addr"}, bus.wb_addr, rd);
    chk({name, "_we"}, bus.wb_we, rd != 5'd0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 5'd3, 1'b1, 32'h12345678, 1'b0, 32'h0,  5'd0, 1'b1, 32'h12345678, 1'b0};
    vecs[1] = '{2'd2, 5'd4, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0,  5'd4, 1'b1, 32'h00000001, 1'b1};
    vecs[2] = '{2'd3, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 32'h40, 5'd0, 1'b1, 32'h00000040, 1'b0};
    vecs[3] = '{2'd0, 5'd0, 1'b1, 32'h0000AAAA, 1'b0, 32'h0,  5'd0, 1'b0, 32'h0000AAAA, 1'b0};
    vecs[4] = '{2'd2, 5'd9, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h9,  5'd9, 1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{2'd0, 5'd7, 1'b1, 32'h00000055, 1'b1, 32'h0,  5'd7, 1'b1, 32'h00000055, 1'b1};
    vecs[6] = '{2'd3, 5'd7, 1'b1, 32'h00000055, 1'b0, 32'h66, 5'd6, 1'b1, 32'h00000066, 1'b0};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.md = 2'd0; bus.rd = '0; bus.rw = 1'b0;
    bus.func_out = '0; bus.nxorv = 1'b0; bus.pc_link = '0;
    bus.ld_size = 2'd0; bus.ld_signed = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_rdata = '0; bus.fwd_qaddr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.in_ready, 1'b0);
    chk("rst_valid", bus.wb_valid, 1'b0);
    chk("rst_we", bus.wb_we, 1'b0);
    chk("rst_addr", bus.wb_addr, 5'd0);
    chk("rst_data", bus.wb_data, 32'h0);
    chk("rst_err", bus.wb_err, 1'b0);
    chk_fwd("rst_fwd", 1'b0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1'b1);

    // Back-to-back table: each result must appear on the very next cycle.
    for (int i = 0; i < 7; i++) begin
      bus.in_valid  = 1'b1;
      bus.md        = vecs[i].md;
      bus.rd        = vecs[i].rd;
      bus.rw        = vecs[i].rw;
      bus.func_out  = vecs[i].func_out;
      bus.nxorv     = vecs[i].nxorv;
      bus.pc_link   = vecs[i].pc_link;
      bus.mem_valid = 1'b1;        // ignored outside WAIT_MEM
      bus.mem_rdata = 32'hFFFF_0000;
      @(negedge clk);
      bus.fwd_qaddr = vecs[i].qaddr;
      #1;
      chk($sformatf("v%0d_valid", i), bus.wb_valid, 1'b1);
      chk($sformatf("v%0d_ready", i), bus.in_ready, 1'b1);
      chk($sformatf("v%0d_we", i), bus.wb_we, vecs[i].exp_we);
      chk($sformatf("v%0d_addr", i), bus.wb_addr, vecs[i].rd);
      chk($sformatf("v%0d_data", i), bus.wb_data, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), bus.wb_err, 1'b0);
      chk_fwd($sformatf("v%0d_fwd", i), vecs[i].exp_hit, vecs[i].exp_data);
    end
    bus.in_valid  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.fwd_qaddr = 5'd7;
    @(negedge clk);
    chk("hold_valid", bus.wb_valid, 1'b0);
    chk("hold_addr", bus.wb_addr, 5'd7);
    chk("hold_data", bus.wb_data, 32'h66);
    chk_fwd("hold_fwd", 1'b0, 32'h0);

    do_load("ld_byte_s", 2'b00, 1'b1, 5'd10, 3, 32'h000000F0, 32'hFFFFFFF0, 1'b0);
    do_load("ld_half_u", 2'b01, 1'b0, 5'd11, 3, 32'hABCD8001, 32'h00008001, 1'b0);
    do_load("ld_half_s", 2'b01, 1'b1, 5'd12, 1, 32'h00008001, 32'hFFFF8001, 1'b0);
    do_load("ld_byte_u", 2'b00, 1'b0, 5'd13, 2, 32'h123456F0, 32'h000000F0, 1'b0);
    do_load("ld_word",   2'b10, 1'b1, 5'd0,  4, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    do_load("ld_edge",   2'b10, 1'b0, 5'd14, 15, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0);
    do_load("ld_tmo",    2'b10, 1'b0, 5'd8,  0, 32'h0,       32'h00000000, 1'b1);

    // Late data after the timeout pulse must not produce another pulse.
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("late_valid", bus.wb_valid, 1'b0);
    chk("late_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("late_valid2", bus.wb_valid, 1'b0);
    chk("late_hold", bus.wb_data, 32'h0);

    // Reset while a load is pending abandons it.
    bus.in_valid = 1'b1; bus.md = 2'd1; bus.rd = 5'd9; bus.rw = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pend_ready", bus.in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("pend_rst_valid", bus.wb_valid, 1'b0);
    reset = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("pend_after_valid", bus.wb_valid, 1'b0);
    chk("pend_after_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk("pend_after_valid2", bus.wb_valid, 1'b0);
    chk("pend_after_data", bus.wb_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
